// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use / multi-cycle-divide stalls, branch flushes and registered EX operand forwarding selects.
// Stall/flush outputs are combinational from state and inputs; forwarding selects and the stall counter are registered.
module hazard_unit #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [4:0]           i_id_rs,
    input  logic [4:0]           i_id_rt,
    input  logic                 i_id_use_rs,
    input  logic                 i_id_use_rt,
    input  logic [4:0]           i_ex_rd,
    input  logic [4:0]           i_mem_rd,
    input  logic [4:0]           i_wb_rd,
    input  logic                 i_ex_reg_write,
    input  logic                 i_mem_reg_write,
    input  logic                 i_wb_reg_write,
    input  logic                 i_ex_mem_read,
    input  logic                 i_branch_taken,
    input  logic                 i_mdu_start,
    input  logic                 i_mdu_done,
    output logic [1:0]           o_fwd_a_sel,
    output logic [1:0]           o_fwd_b_sel,
    output logic                 o_pc_stall,
    output logic                 o_ifid_stall,
    output logic                 o_idex_stall,
    output logic                 o_ifid_flush,
    output logic                 o_idex_flush,
    output logic [CNT_WIDTH-1:0] o_stall_cnt
);

    typedef enum logic [1:0] {RUN, LU_STALL, MDU_BUSY} state_t;

    state_t               r_state;
    logic [1:0]           r_fwd_a_sel;
    logic [1:0]           r_fwd_b_sel;
    logic [CNT_WIDTH-1:0] r_stall_cnt;

    logic       w_load_use;
    logic       w_pc_stall;
    logic       w_idex_stall;
    logic       w_ifid_flush;
    logic       w_idex_flush;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    // Youngest producer wins; code 11 is reachable only through the WB comparison.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic use_src,
                                           input logic ex_we, input logic [4:0] ex_rd,
                                           input logic mem_we, input logic [4:0] mem_rd,
                                           input logic wb_we, input logic [4:0] wb_rd);
        logic [1:0] sel;
        sel = 2'b00;
        if (use_src && ex_we && ex_rd != 5'd0 && ex_rd == src)
            sel = 2'b01;
        else if (use_src && mem_we && mem_rd != 5'd0 && mem_rd == src)
            sel = 2'b10;
        else if (use_src && wb_we && wb_rd != 5'd0 && wb_rd == src)
            sel = 2'b11;
        return sel;
    endfunction

    assign w_load_use = i_ex_mem_read && (i_ex_rd != 5'd0) &&
                        ((i_id_use_rs && i_id_rs == i_ex_rd) || (i_id_use_rt && i_id_rt == i_ex_rd));

    assign w_fwd_a = fwd_sel(i_id_rs, i_id_use_rs, i_ex_reg_write, i_ex_rd,
                             i_mem_reg_write, i_mem_rd, i_wb_reg_write, i_wb_rd);
    assign w_fwd_b = fwd_sel(i_id_rt, i_id_use_rt, i_ex_reg_write, i_ex_rd,
                             i_mem_reg_write, i_mem_rd, i_wb_reg_write, i_wb_rd);

    always_comb begin
        w_pc_stall   = 1'b0;
        w_idex_stall = 1'b0;
        w_ifid_flush = 1'b0;
        w_idex_flush = 1'b0;
        if (i_rst_n) begin
            case (r_state)
                MDU_BUSY: begin
                    w_pc_stall   = !i_mdu_done;
                    w_idex_stall = !i_mdu_done;
                end
                RUN: begin
                    if (i_branch_taken) begin
                        w_ifid_flush = 1'b1;
                        w_idex_flush = 1'b1;
                    end else if (w_load_use) begin
                        w_pc_stall   = 1'b1;
                        w_idex_flush = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= RUN;
            r_fwd_a_sel <= 2'b00;
            r_fwd_b_sel <= 2'b00;
            r_stall_cnt <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (i_mdu_start)
                        r_state <= MDU_BUSY;
                    else if (!i_branch_taken && w_load_use)
                        r_state <= LU_STALL;
                end
                LU_STALL: r_state <= RUN;
                MDU_BUSY: if (i_mdu_done) r_state <= RUN;
                default:  r_state <= RUN;
            endcase

            if (w_idex_flush) begin
                r_fwd_a_sel <= 2'b00;
                r_fwd_b_sel <= 2'b00;
            end else if (!w_idex_stall) begin
                r_fwd_a_sel <= w_fwd_a;
                r_fwd_b_sel <= w_fwd_b;
            end

            if (w_pc_stall && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign o_pc_stall   = w_pc_stall;
    assign o_ifid_stall = w_pc_stall;
    assign o_idex_stall = w_idex_stall;
    assign o_ifid_flush = w_ifid_flush;
    assign o_idex_flush = w_idex_flush;
    assign o_fwd_a_sel  = r_fwd_a_sel;
    assign o_fwd_b_sel  = r_fwd_b_sel;
    assign o_stall_cnt  = r_stall_cnt;

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter CNT_WIDTH, default 32, width of the stall-cycle performance counter.
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 id_rs, id_rt  input  5 each  source register numbers of the instruction in ID.
REQ-005 id_use_rs, id_use_rt  input  1 each  ID instruction actually reads rs/rt.
REQ-006 ex_rd, mem_rd, wb_rd  input  5 each  destination register of the instruction in EX/MEM/WB.
REQ-007 ex_reg_write, mem_reg_write, wb_reg_write  input  1 each  that stage writes the register file.
REQ-008 ex_mem_read  input  1  EX instruction is a load.
REQ-009 branch_taken  input  1  EX resolved a taken branch or jump this cycle.
REQ-010 mdu_start, mdu_done  input  1 each  multi-cycle mul/div issued in EX; result ready.
REQ-011 fwd_a_sel, fwd_b_sel  output  2 each  registered select for the EX-stage 4-input operand muxes: 00 regfile, 01 MEM ALU result, 10 WB data, 11 WB-hold (data written one cycle earlier).
REQ-012 pc_stall, ifid_stall, idex_stall  output  1 each  hold the PC, IF/ID and ID/EX registers.
REQ-013 ifid_flush, idex_flush  output  1 each  load a bubble into IF/ID and ID/EX.
REQ-014 stall_cnt  output  CNT_WIDTH  count of cycles with pc_stall=1.

Function
REQ-015 The FSM SHALL have the states RUN, LU_STALL and MDU_BUSY.
REQ-016 Load-use hazard SHALL be: ex_mem_read and ex_rd!=0 and ((id_use_rs and id_rs==ex_rd) or (id_use_rt and id_rt==ex_rd)).
REQ-017 In RUN, a load-use hazard SHALL combinationally assert pc_stall, ifid_stall and idex_flush in the same cycle and move the FSM to LU_STALL.
REQ-018 LU_STALL SHALL last exactly one cycle with no stall or flush asserted; the FSM SHALL then return to RUN (re-detection is naturally false because the load is now in MEM).
REQ-019 In RUN, mdu_start SHALL move the FSM to MDU_BUSY on the next edge; mdu_start in MDU_BUSY SHALL be ignored.
REQ-020 In MDU_BUSY, pc_stall, ifid_stall and idex_stall SHALL be 1 every cycle until and including the cycle before mdu_done; mdu_done SHALL deassert them combinationally that cycle and return the FSM to RUN.
REQ-021 branch_taken SHALL assert ifid_flush and idex_flush in the same cycle and override a concurrent load-use stall (no stall, FSM stays RUN).
REQ-022 Priority SHALL be: reset > MDU_BUSY > branch_taken > load-use.
REQ-023 Simultaneous branch_taken and mdu_start SHALL flush both registers and still enter MDU_BUSY.
REQ-024 Forwarding for each operand SHALL be computed in ID and registered at the edge, with priority ex match -> 01, mem match -> 10, wb match -> 11, otherwise 00.
REQ-025 A match SHALL require the stage's reg_write=1, its rd!=0, rd equal to the source, and the corresponding id_use bit set.
REQ-026 On an edge where idex_flush=1, fwd_a_sel and fwd_b_sel SHALL load 00.
REQ-027 On an edge where idex_stall=1, fwd_a_sel and fwd_b_sel SHALL hold their values.
REQ-028 stall_cnt SHALL increment by 1 on each edge where pc_stall=1 and SHALL saturate at all-ones.
REQ-029 Select code 11 SHALL be generated only by a wb match.

Reset
REQ-030 With rst_n=0 at an edge, the FSM SHALL go to RUN, fwd_a_sel and fwd_b_sel to 00, and stall_cnt to 0.
REQ-031 While rst_n=0, every stall and flush output SHALL be 0.
REQ-032 Reset asserted in LU_STALL or MDU_BUSY SHALL abort the operation, with no residual stall after release.

Verification
REQ-033 ex: lw ex_rd=5; ID id_rs=5, id_use_rs=1 -> pc_stall=ifid_stall=idex_flush=1 for one cycle; next cycle no stall; the cycle after, fwd_a_sel=10; stall_cnt=1.
REQ-034 ex_reg_write=1 ex_rd=3, mem_reg_write=1 mem_rd=3, id_rt=3, id_use_rt=1 -> after the edge fwd_b_sel=01.
REQ-035 wb_rd=7 wb_reg_write=1 and id_rs=7, no other match -> fwd_a_sel=11; the same with rd=0 -> 00.
REQ-036 mdu_start, then mdu_done after 4 cycles -> stalls high 4 cycles, low in the mdu_done cycle; stall_cnt=4; fwd selects held throughout.
REQ-037 branch_taken together with a load-use hazard -> both flushes=1, pc_stall=0, FSM stays RUN, fwd selects 00 next cycle.
REQ-038 rst_n=0 for one edge during MDU_BUSY -> all outputs 0 and FSM in RUN after release; stall_cnt=0; a later mdu_done has no effect.
